// File: rtl/rggen_axi4lite_reg_bridge.sv
// AXI4-Lite slave to native register-bus bridge: joins AW+W, round-robins against AR, one access in flight.
// Latency: bus request the cycle after grant, response the cycle after i_bus_ready; B/R held until handshake.
module rggen_axi4lite_reg_bridge #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_awvalid,
  output logic                       o_awready,
  input  logic [ADDRESS_WIDTH-1:0]   i_awaddr,
  input  logic                       i_wvalid,
  output logic                       o_wready,
  input  logic [BUS_WIDTH-1:0]       i_wdata,
  input  logic [BUS_WIDTH/8-1:0]     i_wstrb,
  output logic                       o_bvalid,
  input  logic                       i_bready,
  output logic [1:0]                 o_bresp,
  input  logic                       i_arvalid,
  output logic                       o_arready,
  input  logic [ADDRESS_WIDTH-1:0]   i_araddr,
  output logic                       o_rvalid,
  input  logic                       i_rready,
  output logic [1:0]                 o_rresp,
  output logic [BUS_WIDTH-1:0]       o_rdata,
  output logic                       o_bus_valid,
  output logic                       o_bus_write,
  output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
  output logic [BUS_WIDTH-1:0]       o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
  input  logic                       i_bus_ready,
  input  logic [1:0]                 i_bus_status,
  input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int LSB          = $clog2(STROBE_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'((1 << LSB) - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e state;
  state_e state_next;
  logic   write_priority;
  logic   write_request;
  logic   grant_write;
  logic   grant_read;
  logic   bus_done;
  logic   resp_done;

  // Status 01 has no AXI meaning on this bus and is reported as OKAY.
  function automatic logic [1:0] map_status(input logic [1:0] status);
    return (status == 2'b01) ? 2'b00 : status;
  endfunction

  assign write_request = i_awvalid && i_wvalid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    grant_write = 1'b0;
    grant_read  = 1'b0;
    bus_done    = 1'b0;
    resp_done   = 1'b0;
    case (state)
      IDLE: begin
        grant_write = write_request && (write_priority || !i_arvalid);
        grant_read  = i_arvalid && !grant_write;
        if (grant_write || grant_read) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        bus_done = i_bus_ready;
        if (i_bus_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_done = (o_bvalid && i_bready) || (o_rvalid && i_rready);
        if (resp_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_awready = grant_write;
  assign o_wready  = grant_write;
  assign o_arready = grant_read;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      write_priority   <= 1'b1;
      o_bus_valid      <= 1'b0;
      o_bus_write      <= 1'b0;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
      o_bvalid         <= 1'b0;
      o_bresp          <= 2'b00;
      o_rvalid         <= 1'b0;
      o_rresp          <= 2'b00;
      o_rdata          <= '0;
    end else begin
      if (grant_write || grant_read) begin
        write_priority   <= ~write_priority;
        o_bus_valid      <= 1'b1;
        o_bus_write      <= grant_write;
        o_bus_address    <= (grant_write ? i_awaddr : i_araddr) & ALIGN_MASK;
        o_bus_write_data <= grant_write ? i_wdata : '0;
        o_bus_strobe     <= grant_write ? i_wstrb : '1;
      end
      if (bus_done) begin
        o_bus_valid <= 1'b0;
        if (o_bus_write) begin
          o_bvalid <= 1'b1;
          o_bresp  <= map_status(i_bus_status);
          o_rdata  <= '0;
        end else begin
          o_rvalid <= 1'b1;
          o_rresp  <= map_status(i_bus_status);
          o_rdata  <= i_bus_read_data;
        end
      end
      if (o_bvalid && i_bready) begin
        o_bvalid <= 1'b0;
      end
      if (o_rvalid && i_rready) begin
        o_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rggen_axi4lite_reg_bridge.sv
// Directed and randomized checks of the AXI4-Lite register bridge against a transaction-level model.
module tb_rggen_axi4lite_reg_bridge;

  logic        i_clk;
  logic        i_rst;
  logic        i_awvalid;
  logic        o_awready;
  logic [7:0]  i_awaddr;
  logic        i_wvalid;
  logic        o_wready;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        o_bvalid;
  logic        i_bready;
  logic [1:0]  o_bresp;
  logic        i_arvalid;
  logic        o_arready;
  logic [7:0]  i_araddr;
  logic        o_rvalid;
  logic        i_rready;
  logic [1:0]  o_rresp;
  logic [31:0] o_rdata;
  logic        o_bus_valid;
  logic        o_bus_write;
  logic [7:0]  o_bus_address;
  logic [31:0] o_bus_write_data;
  logic [3:0]  o_bus_strobe;
  logic        i_bus_ready;
  logic [1:0]  i_bus_status;
  logic [31:0] i_bus_read_data;

  int errors = 0;
  int checks = 0;

  // AXI response expected for each bus status code
  logic [1:0] resp_map [4] = '{2'b00, 2'b00, 2'b10, 2'b11};

  int   ngr;
  bit   gw   [4];
  int   gcyc [4];
  bit          r_wr;
  logic [7:0]  r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_strb;
  logic [1:0]  r_st;
  logic [31:0] r_rd;

  rggen_axi4lite_reg_bridge #(
    .ADDRESS_WIDTH (8),
    .BUS_WIDTH     (32)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_awvalid        (i_awvalid),
    .o_awready        (o_awready),
    .i_awaddr         (i_awaddr),
    .i_wvalid         (i_wvalid),
    .o_wready         (o_wready),
    .i_wdata          (i_wdata),
    .i_wstrb          (i_wstrb),
    .o_bvalid         (o_bvalid),
    .i_bready         (i_bready),
    .o_bresp          (o_bresp),
    .i_arvalid        (i_arvalid),
    .o_arready        (o_arready),
    .i_araddr         (i_araddr),
    .o_rvalid         (o_rvalid),
    .i_rready         (i_rready),
    .o_rresp          (o_rresp),
    .o_rdata          (o_rdata),
    .o_bus_valid      (o_bus_valid),
    .o_bus_write      (o_bus_write),
    .o_bus_address    (o_bus_address),
    .o_bus_write_data (o_bus_write_data),
    .o_bus_strobe     (o_bus_strobe),
    .i_bus_ready      (i_bus_ready),
    .i_bus_status     (i_bus_status),
    .i_bus_read_data  (i_bus_read_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // One complete transaction from an idle bridge: grant, bus access with wt wait cycles,
  // then the response held for rdly cycles before the ready handshake.
  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int wt, input logic [1:0] st,
                         input logic [31:0] rd, input int rdly, input string tag);
    logic [7:0] exp_addr;
    logic [1:0] exp_resp;
    exp_addr = (addr / 8'd4) * 8'd4;
    exp_resp = resp_map[st];
    if (wr) begin
      i_awvalid = 1'b1; i_wvalid = 1'b1; i_awaddr = addr; i_wdata = data; i_wstrb = strb;
    end else begin
      i_arvalid = 1'b1; i_araddr = addr;
    end
    #1;
    chk({tag, " awready"}, 64'(o_awready), 64'(wr));
    chk({tag, " wready"}, 64'(o_wready), 64'(wr));
    chk({tag, " arready"}, 64'(o_arready), 64'(!wr));
    cyc();
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    i_awaddr = ~addr; i_araddr = ~addr; i_wdata = ~data; i_wstrb = ~strb;
    for (int i = 0; i <= wt; i++) begin
      #1;
      chk({tag, " bus_valid"}, 64'(o_bus_valid), 64'd1);
      chk({tag, " bus_write"}, 64'(o_bus_write), 64'(wr));
      chk({tag, " bus_address"}, 64'(o_bus_address), 64'(exp_addr));
      chk({tag, " bus_write_data"}, 64'(o_bus_write_data), 64'(wr ? data : 32'h0));
      chk({tag, " bus_strobe"}, 64'(o_bus_strobe), 64'(wr ? strb : 4'hF));
      if (i == wt) begin
        i_bus_ready = 1'b1; i_bus_status = st; i_bus_read_data = rd;
      end
      cyc();
    end
    i_bus_ready = 1'b0; i_bus_status = 2'($urandom); i_bus_read_data = $urandom;
    for (int j = 0; j <= rdly; j++) begin
      #1;
      chk({tag, " bus_valid after done"}, 64'(o_bus_valid), 64'd0);
      chk({tag, " bvalid"}, 64'(o_bvalid), 64'(wr));
      chk({tag, " rvalid"}, 64'(o_rvalid), 64'(!wr));
      if (wr) begin
        chk({tag, " bresp"}, 64'(o_bresp), 64'(exp_resp));
        chk({tag, " rdata cleared"}, 64'(o_rdata), 64'd0);
      end else begin
        chk({tag, " rresp"}, 64'(o_rresp), 64'(exp_resp));
        chk({tag, " rdata"}, 64'(o_rdata), 64'(rd));
      end
      if (j == rdly) begin
        i_bready = wr; i_rready = !wr;
      end
      cyc();
    end
    i_bready = 1'b0; i_rready = 1'b0;
    #1;
    chk({tag, " bvalid after handshake"}, 64'(o_bvalid), 64'd0);
    chk({tag, " rvalid after handshake"}, 64'(o_rvalid), 64'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_awvalid = 1'b0; i_awaddr = '0; i_wvalid = 1'b0; i_wdata = '0; i_wstrb = '0;
    i_bready = 1'b0; i_arvalid = 1'b0; i_araddr = '0; i_rready = 1'b0;
    i_bus_ready = 1'b0; i_bus_status = '0; i_bus_read_data = '0;

    // reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset bvalid", 64'(o_bvalid), 64'd0);
    chk("reset rvalid", 64'(o_rvalid), 64'd0);
    chk("reset bus_valid", 64'(o_bus_valid), 64'd0);
    chk("reset bus_address", 64'(o_bus_address), 64'd0);
    chk("reset bus_strobe", 64'(o_bus_strobe), 64'd0);
    chk("reset rdata", 64'(o_rdata), 64'd0);
    i_rst = 1'b0;
    cyc();

    run_txn(1'b1, 8'h14, 32'hDEADBEEF, 4'hF, 0, 2'b00, 32'h0, 0, "write");
    run_txn(1'b0, 8'h23, 32'h0, 4'h0, 3, 2'b10, 32'h12345678, 0, "read_wait");

    // split write: AW alone must be left waiting until W shows up
    i_awvalid = 1'b1; i_awaddr = 8'h08;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("split awready", 64'(o_awready), 64'd0);
      chk("split wready", 64'(o_wready), 64'd0);
      chk("split bus_valid", 64'(o_bus_valid), 64'd0);
      cyc();
    end
    run_txn(1'b1, 8'h08, 32'hA5A5_0F0F, 4'h5, 1, 2'b01, 32'h0, 0, "split");

    // lone W must be left waiting too
    i_wvalid = 1'b1; i_wdata = 32'h1111_2222; i_wstrb = 4'hF;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lone w wready", 64'(o_wready), 64'd0);
      cyc();
    end
    i_wvalid = 1'b0;

    // contention: write and read requests held from reset
    i_rst = 1'b1;
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
    i_awaddr = 8'h10; i_araddr = 8'h30; i_wdata = 32'h0BAD_F00D; i_wstrb = 4'hF;
    i_bus_ready = 1'b1; i_bus_status = 2'b00; i_bus_read_data = 32'h5A5A_5A5A;
    i_bready = 1'b1; i_rready = 1'b1;
    cyc();
    i_rst = 1'b0;
    ngr = 0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      #1;
      if (o_awready || o_arready) begin
        chk("contention no grant while resp pending", 64'(o_bvalid || o_rvalid), 64'd0);
        chk("contention single grant", 64'(o_awready && o_arready), 64'd0);
        gw[ngr] = o_awready;
        gcyc[ngr] = c;
        ngr++;
      end
      cyc();
    end
    chk("contention grant count", 64'(ngr), 64'd4);
    for (int i = 0; i < ngr; i++) begin
      chk("contention grant order", 64'(gw[i]), 64'((i % 2) == 0));
      if (i > 0) chk("contention grant spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
    end
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    repeat (3) cyc();
    i_bus_ready = 1'b0; i_bready = 1'b0; i_rready = 1'b0;

    // backpressure on B, then reset while a response is pending
    run_txn(1'b1, 8'h3C, 32'h7777_8888, 4'hC, 1, 2'b11, 32'h0, 5, "bp");
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_awaddr = 8'h40; i_wdata = 32'h0102_0304; i_wstrb = 4'h3;
    cyc();
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_bus_ready = 1'b1; i_bus_status = 2'b10;
    cyc();
    i_bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall bvalid", 64'(o_bvalid), 64'd1);
      chk("stall bresp", 64'(o_bresp), 64'(2'b10));
      cyc();
    end
    #1 i_rst = 1'b1;
    #1;
    chk("midreset bvalid", 64'(o_bvalid), 64'd0);
    chk("midreset bresp", 64'(o_bresp), 64'd0);
    cyc();
    i_rst = 1'b0; i_bready = 1'b1; i_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post reset no bvalid", 64'(o_bvalid), 64'd0);
      chk("post reset no rvalid", 64'(o_rvalid), 64'd0);
      chk("post reset no bus_valid", 64'(o_bus_valid), 64'd0);
      cyc();
    end
    i_bready = 1'b0; i_rready = 1'b0;
    run_txn(1'b0, 8'h47, 32'h0, 4'h0, 0, 2'b00, 32'hCAFE_F00D, 1, "post_reset_read");

    // randomized transactions
    for (int k = 0; k < 30; k++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 8'($urandom);
      r_data = $urandom;
      r_strb = 4'($urandom);
      r_st   = 2'($urandom);
      r_rd   = $urandom;
      run_txn(r_wr, r_addr, r_data, r_strb, int'($urandom_range(0, 3)), r_st, r_rd,
              int'($urandom_range(0, 2)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
